// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: load-use stalls, operand forwarding,
// branch flushes and data-memory freeze, plus stall/flush performance counters.
module hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwen,
    input  logic [1:0]        ex_wbsel,
    input  logic              ex_pcsel,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwen,
    input  logic              mem_req,
    input  logic              dmem_ready,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwen,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              memwb_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t          state;
    logic [TO_W-1:0] wait_cnt;
    logic            wait_limit;
    logic            freeze;
    logic            timeout_hit;
    logic            load_use;
    logic            branch_flush;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic [REG_AW-1:0] m_rd, input logic m_wen,
                                           input logic [REG_AW-1:0] w_rd, input logic w_wen);
        if (m_wen && m_rd != '0 && m_rd == rs)      return 2'b01;
        else if (w_wen && w_rd != '0 && w_rd == rs) return 2'b10;
        else                                        return 2'b00;
    endfunction

    // The wait cycle that would bring the count up to MEM_TIMEOUT releases instead of freezing.
    assign wait_limit  = (state == MEM_WAIT) &&
                         (({1'b0, wait_cnt} + (TO_W+1)'(1)) == (TO_W+1)'(MEM_TIMEOUT));
    assign freeze      = rst_n && !dmem_ready &&
                         ((state == RUN && mem_req) || (state == MEM_WAIT && !wait_limit));
    assign timeout_hit = rst_n && !dmem_ready && wait_limit;

    assign load_use = ex_regwen && ex_wbsel == 2'b00 && ex_rd != '0 &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign branch_flush = rst_n && !freeze && ex_pcsel;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        fwd_a       = fwd_sel(ex_rs1, mem_rd, mem_regwen, wb_rd, wb_regwen);
        fwd_b       = fwd_sel(ex_rs2, mem_rd, mem_regwen, wb_rd, wb_regwen);
        mem_timeout = timeout_hit;
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
            mem_timeout = 1'b0;
        end else if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_pcsel) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // Hold IF/ID and the PC, push one bubble into EX.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= TO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready || wait_limit) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
            if (!pc_en)       stall_cnt <= stall_cnt + PERF_W'(1);
            if (branch_flush) flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end

endmodule
